jtag_tap_param: RTL and testbench

- Parametrised next-generation JTAG test access port: full IEEE 1149.1 16-state TAP controller, an IR of configurable width, and mandatory BYPASS and IDCODE data registers.
- Adds NUM_USER user data registers (UDRs) with parallel capture and update ports, so on-chip blocks (debug, MBIST, config) attach without editing the TAP.
- Sits between the chip-level JTAG pins and the debug/test blocks; runs entirely in the tck domain.

---
 rtl/jtag_tap_param.sv | 172 +++++++++++++++++
 tb/tb_jtag_tap_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_param.sv
// jtag_tap_param: IEEE 1149.1 TAP controller with configurable IR, BYPASS,
// IDCODE and NUM_USER user data registers exposing parallel capture/update.
// Everything runs on tck; tdo/tdo_en are launched on the falling edge.
module jtag_tap_param #(
  parameter int                  IR_WIDTH       = 8,
  parameter logic [31:0]         IDCODE_VALUE   = 32'h1DC0_0001,
  parameter logic [IR_WIDTH-1:0] INSN_IDCODE    = IR_WIDTH'(8'h01),
  parameter logic [IR_WIDTH-1:0] INSN_USER_BASE = IR_WIDTH'(8'h10),
  parameter int                  NUM_USER       = 4,
  parameter int                  UDR_WIDTH      = 32
) (
  input  logic                          tck,
  input  logic                          trst,
  input  logic                          tms,
  input  logic                          tdi,
  output logic                          tdo,
  output logic                          tdo_en,
  output logic [IR_WIDTH-1:0]           ir,
  output logic [NUM_USER-1:0]           udr_sel,
  input  logic [NUM_USER*UDR_WIDTH-1:0] udr_capture_data,
  output logic [NUM_USER*UDR_WIDTH-1:0] udr_update_data,
  output logic [NUM_USER-1:0]           udr_update,
  output logic [NUM_USER-1:0]           udr_capture
);

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
  } tap_state_t;

  tap_state_t            state_reg, state_next;
  logic [IR_WIDTH-1:0]   ir_reg, ir_sr_reg, ir_shifted;
  logic                  bypass_reg;
  logic [31:0]           idcode_sr_reg;
  // One shift register serves whichever UDR is selected; only one can be
  // selected at a time, so per-UDR shift registers would never differ.
  logic [UDR_WIDTH-1:0]  udr_sr_reg, udr_shifted, udr_cap_mux;
  logic [UDR_WIDTH-1:0]  udr_data_reg [NUM_USER];
  logic [NUM_USER-1:0]   udr_update_reg;
  logic                  tdo_reg, tdo_en_reg;
  logic                  all_ones, sel_idcode, sel_udr, dr_lsb;

  // Instruction decode: all-ones is BYPASS and wins over any other match;
  // unknown opcodes fall through to BYPASS.
  assign all_ones   = &ir_reg;
  assign sel_idcode = !all_ones && (ir_reg == INSN_IDCODE);
  assign sel_udr    = |udr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_USER; gi++) begin : g_udr
      assign udr_sel[gi] = !all_ones && !sel_idcode &&
                           (ir_reg == INSN_USER_BASE + IR_WIDTH'(gi));
      assign udr_update_data[gi*UDR_WIDTH +: UDR_WIDTH] = udr_data_reg[gi];
    end
  endgenerate

  assign ir          = ir_reg;
  assign tdo         = tdo_reg;
  assign tdo_en      = tdo_en_reg;
  assign udr_update  = udr_update_reg;
  // Capture pulse coincides with the edge that loads the shift register.
  assign udr_capture = (state_reg == ST_CAP_DR) ? udr_sel : '0;

  // State register.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_reg <= ST_TLR;
    else       state_reg <= state_next;
  end

  // TMS-driven next-state logic (standard 16-state graph).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_TLR:      state_next = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      state_next = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_next = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_next = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_next = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: state_next = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_next = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: state_next = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_next = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_next = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_next = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_next = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: state_next = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_next = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: state_next = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_next = tms ? ST_SEL_DR   : ST_RTI;
      default:     state_next = ST_TLR;
    endcase
  end

  // Shift-right helpers (written so a 1-bit register still works) and the
  // capture-data mux for the selected UDR.
  always_comb begin
    ir_shifted                = ir_sr_reg >> 1;
    ir_shifted[IR_WIDTH-1]    = tdi;
    udr_shifted               = udr_sr_reg >> 1;
    udr_shifted[UDR_WIDTH-1]  = tdi;
    udr_cap_mux               = '0;
    for (int i = 0; i < NUM_USER; i++) begin
      if (udr_sel[i]) udr_cap_mux = udr_capture_data[i*UDR_WIDTH +: UDR_WIDTH];
    end
    dr_lsb = sel_idcode ? idcode_sr_reg[0] : (sel_udr ? udr_sr_reg[0] : bypass_reg);
  end

  // Instruction register path: capture pattern, shift, update; any entry
  // into Test-Logic-Reset restores IDCODE as the active instruction.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr_reg <= '0;
      ir_reg    <= INSN_IDCODE;
    end else begin
      if (state_reg == ST_CAP_IR)        ir_sr_reg <= IR_WIDTH'(2'b01);
      else if (state_reg == ST_SHIFT_IR) ir_sr_reg <= ir_shifted;
      if (state_next == ST_TLR)          ir_reg <= INSN_IDCODE;
      else if (state_reg == ST_UPD_IR)   ir_reg <= ir_sr_reg;
    end
  end

  // Data register shift chains; only the selected one moves in Shift-DR.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_reg    <= 1'b0;
      idcode_sr_reg <= '0;
      udr_sr_reg    <= '0;
    end else if (state_reg == ST_CAP_DR) begin
      bypass_reg <= 1'b0;
      if (sel_idcode) idcode_sr_reg <= IDCODE_VALUE;
      if (sel_udr)    udr_sr_reg    <= udr_cap_mux;
    end else if (state_reg == ST_SHIFT_DR) begin
      if (sel_idcode)   idcode_sr_reg <= {tdi, idcode_sr_reg[31:1]};
      else if (sel_udr) udr_sr_reg    <= udr_shifted;
      else              bypass_reg    <= tdi;
    end
  end

  // UDR parallel outputs; the update pulse is registered so it lines up
  // with the cycle in which the new slice value is first visible.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      udr_update_reg <= '0;
      for (int i = 0; i < NUM_USER; i++) udr_data_reg[i] <= '0;
    end else begin
      udr_update_reg <= (state_reg == ST_UPD_DR) ? udr_sel : '0;
      for (int i = 0; i < NUM_USER; i++) begin
        if (state_reg == ST_UPD_DR && udr_sel[i]) udr_data_reg[i] <= udr_sr_reg;
      end
    end
  end

  // Falling-edge tdo launch: chain LSB while shifting, otherwise quiet.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_reg    <= 1'b0;
      tdo_en_reg <= 1'b0;
    end else if (state_reg == ST_SHIFT_IR) begin
      tdo_reg    <= ir_sr_reg[0];
      tdo_en_reg <= 1'b1;
    end else if (state_reg == ST_SHIFT_DR) begin
      tdo_reg    <= dr_lsb;
      tdo_en_reg <= 1'b1;
    end else begin
      tdo_reg    <= 1'b0;
      tdo_en_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Testbench for jtag_tap_param: directed scans plus randomized IR/DR scans
// checked against a scan-chain model (captured value followed by tdi bits).
module tb_jtag_tap_param;
  localparam int NU = 4;
  localparam int UW = 32;

  logic          tck = 1'b0, trst = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic          tdo, tdo_en;
  logic [7:0]    ir;
  logic [NU-1:0] udr_sel, udr_update, udr_capture;
  logic [NU*UW-1:0] udr_capture_data, udr_update_data;

  jtag_tap_param dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .ir(ir), .udr_sel(udr_sel), .udr_capture_data(udr_capture_data),
    .udr_update_data(udr_update_data), .udr_update(udr_update),
    .udr_capture(udr_capture)
  );

  always #5 tck = ~tck;

  int          total = 0, passed = 0;
  int          upd_cnt [NU];
  int          cap_cnt [NU];
  int          en_cnt;
  logic        last_tdo, last_en;
  logic [31:0] model_udr [NU];
  logic [7:0]  model_ir;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_counts();
    en_cnt = 0;
    for (int i = 0; i < NU; i++) begin upd_cnt[i] = 0; cap_cnt[i] = 0; end
  endtask

  // One tck cycle: sample tdo side after the falling edge, drive tms/tdi,
  // then sample the rising-edge outputs just after the rising edge.
  task automatic step(input logic t_ms, input logic t_di);
    @(negedge tck); #1;
    last_tdo = tdo; last_en = tdo_en;
    if (tdo_en === 1'b1) en_cnt++;
    tms = t_ms; tdi = t_di;
    @(posedge tck); #1;
    for (int i = 0; i < NU; i++) begin
      if (udr_update[i]  === 1'b1) upd_cnt[i]++;
      if (udr_capture[i] === 1'b1) cap_cnt[i]++;
    end
  endtask

  // Reference decode: chain length and captured value for an opcode.
  function automatic int user_idx(input logic [7:0] op);
    if (op != 8'hFF && op != 8'h01 && op >= 8'h10 && op < 8'h10 + NU) return int'(op) - 16;
    return -1;
  endfunction
  function automatic int reg_len(input logic [7:0] op);
    if (op == 8'h01 || user_idx(op) >= 0) return 32;
    return 1;
  endfunction
  function automatic logic [31:0] reg_cap(input logic [7:0] op);
    if (op == 8'h01) return 32'h1DC0_0001;
    if (user_idx(op) >= 0) return udr_capture_data[user_idx(op)*UW +: UW];
    return 32'h0;
  endfunction

  function automatic logic [127:0] exp_udr_bus();
    logic [127:0] v;
    for (int i = 0; i < NU; i++) v[i*UW +: UW] = model_udr[i];
    return v;
  endfunction

  function automatic logic [127:0] pulse_word();
    logic [127:0] v = '0;
    for (int i = 0; i < NU; i++) begin
      v[4*i +: 4]      = 4'((upd_cnt[i] > 15) ? 15 : upd_cnt[i]);
      v[16 + 4*i +: 4] = 4'((cap_cnt[i] > 15) ? 15 : cap_cnt[i]);
    end
    return v;
  endfunction

  // From Run-Test/Idle: load an 8-bit instruction, return the shifted-out bits.
  task automatic scan_ir(input logic [7:0] din, output logic [7:0] dout);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int k = 0; k < 8; k++) begin
      step(k == 7, din[k]);
      dout[k] = last_tdo;
    end
    step(1, 0); step(0, 0);
    model_ir = din;
  endtask

  // From Run-Test/Idle: n-bit DR scan, optional pause after pause_at bits.
  task automatic scan_dr(input int n, input logic [63:0] din, input int pause_at,
                         output logic [63:0] dout);
    dout = '0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int k = 0; k < n; k++) begin
      step((k == n-1) || (k == pause_at-1), din[k]);
      dout[k] = last_tdo;
      if (k == pause_at-1 && k != n-1) begin
        step(0, 0);
        for (int p = 0; p < 10; p++) step(0, 0);
        step(1, 0); step(0, 0);
      end
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic do_dr(input string tag, input int n, input logic [63:0] din_raw, input int pause_at);
    logic [63:0]  din, dout;
    logic [127:0] c, pexp;
    int           len, idx;
    din  = din_raw & ((64'd1 << n) - 64'd1);
    len  = reg_len(model_ir);
    idx  = user_idx(model_ir);
    c    = 128'(reg_cap(model_ir)) | (128'(din) << len);
    clear_counts();
    scan_dr(n, din, pause_at, dout);
    check({tag, ".tdo"}, 128'(dout), c & ((128'd1 << n) - 128'd1));
    check({tag, ".en"}, 128'(en_cnt), 128'(n));
    pexp = '0;
    if (idx >= 0) begin
      model_udr[idx] = 32'(c >> n);
      pexp[4*idx] = 1'b1;
      pexp[16 + 4*idx] = 1'b1;
    end
    check({tag, ".pulses"}, pulse_word(), pexp);
    check({tag, ".udr"}, udr_update_data, exp_udr_bus());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ir"}, 128'(ir), 128'(8'h01));
    check({tag, ".tdo"}, 128'({tdo_en, tdo}), 128'(2'b00));
    check({tag, ".udr"}, udr_update_data, 128'(0));
    check({tag, ".pulse"}, 128'({udr_update, udr_capture, udr_sel}), 128'(0));
  endtask

  initial begin
    logic [7:0]  irout, op;
    logic [7:0]  ops [8];
    logic [63:0] d;
    logic [127:0] c;
    int          n, pa;
    ops = '{8'h01, 8'hFF, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h5A};
    udr_capture_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NU; i++) model_udr[i] = '0;
    model_ir = 8'h01;
    clear_counts();

    // Reset state while trst is held low.
    #12;
    check_reset_outputs("reset");
    @(negedge tck); #2 trst = 1'b1;
    step(0, 0);

    // IDCODE with the default instruction.
    do_dr("idcode", 32, {$urandom, $urandom}, 0);

    // BYPASS via all-ones: tdi 1,0,1,1 -> tdo 0,1,0,1.
    scan_ir(8'hFF, irout);
    check("bypass.ir", 128'(ir), 128'(8'hFF));
    check("bypass.sel", 128'(udr_sel), 128'(0));
    do_dr("bypass", 4, 64'b1101, 0);

    // UDR2 capture/update.
    udr_capture_data[2*UW +: UW] = 32'hCAFE_F00D;
    scan_ir(8'h12, irout);
    check("udr2.sel", 128'(udr_sel), 128'(4'b0100));
    do_dr("udr2", 32, 64'h1234_5678, 0);
    check("udr2.slice", 128'(udr_update_data[2*UW +: UW]), 128'(32'h1234_5678));

    // IR capture pattern, then unused opcode behaves as BYPASS.
    scan_ir(8'h3C, irout);
    check("ircap", 128'(irout), 128'(8'h01));
    check("unused.sel", 128'(udr_sel), 128'(0));
    do_dr("unused", 5, {$urandom, $urandom}, 0);

    // Pause-DR in the middle of a UDR1 scan.
    scan_ir(8'h11, irout);
    do_dr("pause", 32, {$urandom, $urandom}, 13);

    // Randomized instruction / length / pause scans.
    for (int it = 0; it < 12; it++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 8'h5A) op = 8'($urandom_range(0, 255));
      udr_capture_data = {$urandom, $urandom, $urandom, $urandom};
      scan_ir(op, irout);
      check($sformatf("rnd%0d.ir", it), 128'(ir), 128'(op));
      n  = $urandom_range(1, 64);
      pa = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n-1) : 0;
      do_dr($sformatf("rnd%0d", it), n, {$urandom, $urandom}, pa);
    end

    // Five tms=1 during a UDR1 shift. The TMS graph walks through
    // Update-DR, so slice 1 takes the partially shifted value; the first
    // tms=1 cycle still shifts (tdi=0).
    udr_capture_data = {$urandom, $urandom, $urandom, $urandom};
    scan_ir(8'h11, irout);
    d = 64'($urandom) & 64'h3FF;
    c = 128'(udr_capture_data[1*UW +: UW]) | (128'(d) << 32);
    step(1, 0); step(0, 0); step(0, 0);
    for (int k = 0; k < 10; k++) step(0, d[k]);
    for (int k = 0; k < 5; k++) step(1, 0);
    model_udr[1] = 32'(c >> 11);
    model_ir = 8'h01;
    check("tmsrst.ir", 128'(ir), 128'(8'h01));
    check("tmsrst.sel", 128'(udr_sel), 128'(0));
    check("tmsrst.udr", udr_update_data, exp_udr_bus());
    step(0, 0);

    // trst mid-shift on UDR3: outputs clear without any tck edge.
    scan_ir(8'h13, irout);
    step(1, 0); step(0, 0); step(0, 0);
    for (int k = 0; k < 7; k++) step(0, 1'($urandom));
    check("trst.pre_en", 128'(last_en), 128'(1));
    #1 trst = 1'b0;
    #1;
    check_reset_outputs("trst");
    for (int i = 0; i < NU; i++) model_udr[i] = '0;
    model_ir = 8'h01;
    @(negedge tck); #2 trst = 1'b1;
    step(0, 0);
    do_dr("recover", 32, {$urandom, $urandom}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
